// File: rtl/vga_timing_gen.sv
// Raster timing generator: hs/vs/blank, look-ahead rd_req, x/y, sol/sof, frame count.
// Latency: outputs registered, one cycle behind the h/v counters; enable-to-first-sof is 2 cycles.
// Backpressure: none; the raster free-runs and rd_req must be honoured by the pixel FIFO.
module vga_timing_gen #(
   parameter int HDISP   = 800,
   parameter int HFP     = 40,
   parameter int HPULSE  = 48,
   parameter int HBP     = 40,
   parameter int VDISP   = 480,
   parameter int VFP     = 13,
   parameter int VPULSE  = 3,
   parameter int VBP     = 29,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int RD_LEAD = 1,
   parameter int FCNT_W  = 16
) (
   input  logic                       pixel_clk,
   input  logic                       pixel_rst_n,
   input  logic                       enable,
   output logic                       hs,
   output logic                       vs,
   output logic                       blank,
   output logic                       rd_req,
   output logic [$clog2(HDISP)-1:0]   x,
   output logic [$clog2(VDISP)-1:0]   y,
   output logic                       sol,
   output logic                       sof,
   output logic [FCNT_W-1:0]          frame_cnt,
   output logic                       running
);

   localparam int HBLANK = HFP + HPULSE + HBP;
   localparam int HTOTAL = HBLANK + HDISP;
   localparam int VBLANK = VFP + VPULSE + VBP;
   localparam int VTOTAL = VBLANK + VDISP;
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);
   localparam int XW     = $clog2(HDISP);
   localparam int YW     = $clog2(VDISP);

   localparam logic [HW-1:0] H_SYNC_S = HW'(HFP);
   localparam logic [HW-1:0] H_SYNC_E = HW'(HFP + HPULSE);
   localparam logic [HW-1:0] H_ACT    = HW'(HBLANK);
   localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
   localparam logic [VW-1:0] V_SYNC_S = VW'(VFP);
   localparam logic [VW-1:0] V_SYNC_E = VW'(VFP + VPULSE);
   localparam logic [VW-1:0] V_ACT    = VW'(VBLANK);
   localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);

   // One extra bit so h + RD_LEAD cannot wrap near the end of the line.
   localparam logic [HW:0]   H_ACT_X  = (HW+1)'(HBLANK);
   localparam logic [HW:0]   H_TOT_X  = (HW+1)'(HTOTAL);
   localparam logic [HW:0]   LEAD_X   = (HW+1)'(RD_LEAD);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Refuse to build a raster with empty porch/sync windows or a lead past the back porch.
   generate
      if (RD_LEAD < 0 || RD_LEAD > HBP || HFP < 1 || HPULSE < 1 || HBP < 1 ||
          VFP < 1 || VPULSE < 1 || VBP < 1) begin : g_bad_cfg
         $error("vga_timing_gen: illegal porch/sync/RD_LEAD parameters");
      end
   endgenerate

   logic [1:0]    state, state_nxt;
   logic [HW-1:0] h, h_nxt;
   logic [VW-1:0] v, v_nxt;
   logic          h_end, frame_end;

   logic          act;
   logic          hs_nxt, vs_nxt, blank_nxt, rd_nxt, sol_nxt, sof_nxt;
   logic [XW-1:0] x_nxt;
   logic [YW-1:0] y_nxt;
   logic [HW:0]   h_lead;

   assign h_end     = (h == H_LAST);
   assign frame_end = h_end && (v == V_LAST);
   assign act       = (state != ST_IDLE);

   // Run/drain FSM and raster counters; drain only exits on the last pixel of a frame.
   always_comb begin
      state_nxt = state;
      h_nxt     = h;
      v_nxt     = v;
      case (state)
         ST_IDLE: begin
            h_nxt = '0;
            v_nxt = '0;
            if (enable) state_nxt = ST_RUN;
         end
         ST_RUN, ST_DRAIN: begin
            if (h_end) begin
               h_nxt = '0;
               v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
               h_nxt = h + 1'b1;
            end
            if (state == ST_RUN) begin
               if (!enable) state_nxt = ST_DRAIN;
            end else if (enable) begin
               state_nxt = ST_RUN;
            end else if (frame_end) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            h_nxt     = '0;
            v_nxt     = '0;
         end
      endcase
   end

   // Decode of the current counter position; everything is forced idle outside RUN/DRAIN.
   always_comb begin
      h_lead    = {1'b0, h} + LEAD_X;
      hs_nxt    = (act && h >= H_SYNC_S && h < H_SYNC_E) ? HS_POL : ~HS_POL;
      vs_nxt    = (act && v >= V_SYNC_S && v < V_SYNC_E) ? VS_POL : ~VS_POL;
      blank_nxt = act && (h >= H_ACT) && (v >= V_ACT);
      x_nxt     = blank_nxt ? XW'(h - H_ACT) : '0;
      y_nxt     = blank_nxt ? YW'(v - V_ACT) : '0;
      rd_nxt    = act && (v >= V_ACT) && (h_lead >= H_ACT_X) && (h_lead < H_TOT_X);
      sol_nxt   = act && (h == '0);
      sof_nxt   = sol_nxt && (v == '0);
   end

   // State and counter registers.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         state <= ST_IDLE;
         h     <= '0;
         v     <= '0;
      end else begin
         state <= state_nxt;
         h     <= h_nxt;
         v     <= v_nxt;
      end
   end

   // Output registers; frame_cnt steps in the same edge that raises sof.
   always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
      if (!pixel_rst_n) begin
         hs        <= ~HS_POL;
         vs        <= ~VS_POL;
         blank     <= 1'b0;
         rd_req    <= 1'b0;
         x         <= '0;
         y         <= '0;
         sol       <= 1'b0;
         sof       <= 1'b0;
         frame_cnt <= '0;
         running   <= 1'b0;
      end else begin
         hs        <= hs_nxt;
         vs        <= vs_nxt;
         blank     <= blank_nxt;
         rd_req    <= rd_nxt;
         x         <= x_nxt;
         y         <= y_nxt;
         sol       <= sol_nxt;
         sof       <= sof_nxt;
         running   <= act;
         if (sof_nxt) frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using two scaled rasters.
// A: 8x4 active, porches 2/3/2 and 1/2/2, RD_LEAD=2 (15x9 = 135 cycles/frame).
// B: 4x2 active, all porches 1, high-active syncs, RD_LEAD=0, FCNT_W=2 (7x5 = 35 cycles/frame).
module tb_vga_timing_gen;

   localparam int A_HT = 15;
   localparam int A_VT = 9;
   localparam int A_FR = A_HT * A_VT;
   localparam int B_FR = 35;

   logic pixel_clk;
   logic pixel_rst_n;
   logic a_en, b_en;

   logic       a_hs, a_vs, a_blank, a_rd_req, a_sol, a_sof, a_running;
   logic [2:0] a_x;
   logic [1:0] a_y;
   logic [7:0] a_frame_cnt;

   logic       b_hs, b_vs, b_blank, b_rd_req, b_sol, b_sof, b_running;
   logic [1:0] b_x;
   logic [0:0] b_y;
   logic [1:0] b_frame_cnt;

   int checks   = 0;
   int failures = 0;

   vga_timing_gen #(
      .HDISP(8), .HFP(2), .HPULSE(3), .HBP(2),
      .VDISP(4), .VFP(1), .VPULSE(2), .VBP(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .RD_LEAD(2), .FCNT_W(8)
   ) u_dut_a (
      .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(a_en),
      .hs(a_hs), .vs(a_vs), .blank(a_blank), .rd_req(a_rd_req),
      .x(a_x), .y(a_y), .sol(a_sol), .sof(a_sof),
      .frame_cnt(a_frame_cnt), .running(a_running)
   );

   vga_timing_gen #(
      .HDISP(4), .HFP(1), .HPULSE(1), .HBP(1),
      .VDISP(2), .VFP(1), .VPULSE(1), .VBP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .RD_LEAD(0), .FCNT_W(2)
   ) u_dut_b (
      .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .enable(b_en),
      .hs(b_hs), .vs(b_vs), .blank(b_blank), .rd_req(b_rd_req),
      .x(b_x), .y(b_y), .sol(b_sol), .sof(b_sof),
      .frame_cnt(b_frame_cnt), .running(b_running)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge pixel_clk);
   endtask

   logic bl [A_FR];
   logic rq [A_FR];

   initial begin
      int bl_cnt, rq_cnt, hs_bad, vs_bad, xy_bad, sol_bad, sof_cnt, lead_bad, early_rq;
      int first_bl, fx, fy, lx, ly, hl, vl, k, sofs, rlow;
      int b_hs_cnt, b_vs_cnt, b_bl_cnt, b_rq_bad;
      logic       prev_bl;
      logic [2:0] prev_x;
      logic [1:0] prev_y;
      logic [1:0] exp_fc;

      pixel_rst_n = 1'b1;
      a_en = 1'b0;
      b_en = 1'b0;
      #1 pixel_rst_n = 1'b0;
      #2;
      // Reset values, before any clock edge.
      chk("rst_a_hs", a_hs, 1);
      chk("rst_a_vs", a_vs, 1);
      chk("rst_a_blank", a_blank, 0);
      chk("rst_a_rd_req", a_rd_req, 0);
      chk("rst_a_xy", {a_x, a_y}, 0);
      chk("rst_a_sol_sof", {a_sol, a_sof}, 0);
      chk("rst_a_frame_cnt", a_frame_cnt, 0);
      chk("rst_a_running", a_running, 0);
      chk("rst_b_hs", b_hs, 0);
      chk("rst_b_vs", b_vs, 0);
      chk("rst_b_frame_cnt", b_frame_cnt, 0);

      step();
      step();
      pixel_rst_n = 1'b1;
      step();
      step();
      chk("idle_running", a_running, 0);
      chk("idle_sof", a_sof, 0);

      // Start raster A: running and the first sof two cycles after enable.
      a_en = 1'b1;
      step();
      chk("start_c1_running", a_running, 0);
      step();
      chk("start_sof", a_sof, 1);
      chk("start_running", a_running, 1);
      chk("start_frame_cnt", a_frame_cnt, 1);

      // Capture one full frame, index t = 15*line + pixel.
      bl_cnt = 0; rq_cnt = 0; hs_bad = 0; vs_bad = 0; xy_bad = 0; sol_bad = 0;
      sof_cnt = 0; lead_bad = 0; early_rq = 0; first_bl = -1; fx = -1; fy = -1; lx = -1; ly = -1;
      for (int t = 0; t < A_FR; t++) begin
         if (t > 0) step();
         hl = t % A_HT;
         vl = t / A_HT;
         bl[t] = a_blank;
         rq[t] = a_rd_req;
         if (a_blank) begin
            bl_cnt++;
            if (first_bl < 0) begin
               first_bl = t;
               fx = int'(a_x);
               fy = int'(a_y);
            end
            lx = int'(a_x);
            ly = int'(a_y);
            if (int'(a_x) != hl - 7 || int'(a_y) != vl - 5) xy_bad++;
         end else if (a_x != 3'd0 || a_y != 2'd0) begin
            xy_bad++;
         end
         if (a_rd_req) rq_cnt++;
         if (a_rd_req && vl < 5) early_rq++;
         if ((a_hs == 1'b0) != (hl >= 2 && hl < 5)) hs_bad++;
         if ((a_vs == 1'b0) != (vl >= 1 && vl < 3)) vs_bad++;
         if (a_sol != (hl == 0)) sol_bad++;
         if (a_sof) sof_cnt++;
      end
      for (int t = 0; t < A_FR; t++) begin
         if (rq[t] != ((t + 2 < A_FR) ? bl[t + 2] : 1'b0)) lead_bad++;
      end
      chk("frame_blank_count", bl_cnt, 32);
      chk("frame_rdreq_count", rq_cnt, 32);
      chk("first_blank_pos", first_bl, 82);
      chk("first_blank_xy", {fx[15:0], fy[15:0]}, 0);
      chk("last_blank_x", lx, 7);
      chk("last_blank_y", ly, 3);
      chk("xy_pattern_bad", xy_bad, 0);
      chk("hs_window_bad", hs_bad, 0);
      chk("vs_window_bad", vs_bad, 0);
      chk("sol_pattern_bad", sol_bad, 0);
      chk("sof_per_frame", sof_cnt, 1);
      chk("rdreq_lead_bad", lead_bad, 0);
      chk("rdreq_in_vblank", early_rq, 0);

      step();
      chk("frame2_sof", a_sof, 1);
      chk("frame2_cnt", a_frame_cnt, 2);

      // Drop enable mid-active-area; the frame must complete then stop.
      repeat (90) step();
      a_en = 1'b0;
      k = 0;
      sofs = 0;
      prev_bl = 1'b0;
      prev_x = '0;
      prev_y = '0;
      while (k < 200 && a_running) begin
         prev_bl = a_blank;
         prev_x = a_x;
         prev_y = a_y;
         step();
         k++;
         if (a_sof) sofs++;
      end
      chk("drain_cycles", k, 45);
      chk("drain_sof", sofs, 0);
      chk("drain_last_blank", prev_bl, 1);
      chk("drain_last_xy", {prev_x, prev_y}, {3'd7, 2'd3});
      chk("drained_hs_vs", {a_hs, a_vs}, 2'b11);
      chk("drained_blank", a_blank, 0);
      sofs = 0;
      repeat (50) begin
         step();
         if (a_sof || a_running) sofs++;
      end
      chk("stopped_no_activity", sofs, 0);
      chk("stopped_frame_cnt", a_frame_cnt, 2);

      // Restart, then toggle enable within a frame: no gap, no restart.
      a_en = 1'b1;
      step();
      step();
      chk("restart_sof", a_sof, 1);
      chk("restart_frame_cnt", a_frame_cnt, 3);
      sofs = 0;
      rlow = 0;
      for (int t = 1; t <= A_FR; t++) begin
         step();
         if (t == 30) a_en = 1'b0;
         if (t == 60) a_en = 1'b1;
         if (!a_running) rlow++;
         if (a_sof && t < A_FR) sofs++;
      end
      chk("toggle_next_sof", a_sof, 1);
      chk("toggle_frame_cnt", a_frame_cnt, 4);
      chk("toggle_extra_sof", sofs, 0);
      chk("toggle_running_gap", rlow, 0);

      // Asynchronous reset in the middle of an active line.
      repeat (85) step();
      chk("pre_reset_blank", a_blank, 1);
      #1 pixel_rst_n = 1'b0;
      #1;
      chk("async_rst_hs_vs", {a_hs, a_vs}, 2'b11);
      chk("async_rst_blank_rd", {a_blank, a_rd_req}, 0);
      chk("async_rst_xy", {a_x, a_y}, 0);
      chk("async_rst_frame_cnt", a_frame_cnt, 0);
      chk("async_rst_running", a_running, 0);
      step();
      pixel_rst_n = 1'b1;
      step();
      step();
      chk("post_rst_sof", a_sof, 1);
      chk("post_rst_frame_cnt", a_frame_cnt, 1);

      // Raster B: high-active syncs, rd_req == blank, 2-bit frame counter wrap.
      a_en = 1'b0;
      b_en = 1'b1;
      step();
      step();
      chk("b_first_sof", b_sof, 1);
      chk("b_first_frame_cnt", b_frame_cnt, 1);
      b_hs_cnt = 0; b_vs_cnt = 0; b_bl_cnt = 0; b_rq_bad = 0;
      for (int t = 0; t < B_FR; t++) begin
         if (t > 0) step();
         if (b_hs) b_hs_cnt++;
         if (b_vs) b_vs_cnt++;
         if (b_blank) b_bl_cnt++;
         if (b_rd_req != b_blank) b_rq_bad++;
         if (b_hs != ((t % 7) == 1)) b_hs_cnt += 100;
         if (b_vs != ((t / 7) == 1)) b_vs_cnt += 100;
      end
      chk("b_hs_high_cycles", b_hs_cnt, 5);
      chk("b_vs_high_cycles", b_vs_cnt, 7);
      chk("b_blank_count", b_bl_cnt, 8);
      chk("b_rdreq_eq_blank", b_rq_bad, 0);
      exp_fc = 2'd2;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b_wrap_sof", b_sof, 1);
         chk("b_wrap_frame_cnt", b_frame_cnt, exp_fc);
         exp_fc = exp_fc + 2'd1;
         if (i < 3) repeat (B_FR - 1) step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
